// File: rtl/gnn_serial_engine_if.sv
// Stream bundle for gnn_serial_engine.
//   in_valid/in_ready/in_data : one node's four 5-bit signed features per beat
//   out_valid/out_ready       : one node's result per beat
//   out_node                  : node index of the current result
//   out0/out1                 : signed layer-2 outputs for out_node
// master = producer of features / consumer of results, slave = the engine.
interface gnn_serial_engine_if;
  logic               in_valid;
  logic               in_ready;
  logic [19:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_node;
  logic signed [20:0] out0;
  logic signed [20:0] out1;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_node, out0, out1
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_node, out0, out1
  );
endinterface

// File: rtl/gnn_serial_engine.sv
// Time-multiplexed two-layer GNN on a 4-node ring graph.
// A single 15x5 signed multiplier and 21-bit accumulator serve both layers,
// sequenced LOAD -> AGG1 -> MAC1 -> AGG2 -> MAC2 -> OUT.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   w1 [79:0]: layer-1 weights, feature k -> hidden j at [(4j+k)*5 +: 5]
//   w2 [39:0]: layer-2 weights, hidden k -> output o at [(4o+k)*5 +: 5]
//   busy     : high in every state except LOAD
//   bus      : feature input / result output streams (slave side)
module gnn_serial_engine (
  input  logic                clk,
  input  logic                rst,
  input  logic [79:0]         w1,
  input  logic [39:0]         w2,
  output logic                busy,
  gnn_serial_engine_if.slave  bus
);
  typedef enum logic [2:0] {LOAD, AGG1, MAC1, AGG2, MAC2, OUT} state_t;
  state_t state, state_nx;

  logic [1:0]         ncnt;   // node index: load slot in LOAD, result index in OUT
  logic [5:0]         cnt;    // MAC step; MAC1 {n,j,k}, MAC2 {n,o,k}
  logic [79:0]        w1r;
  logic [39:0]        w2r;
  logic signed [4:0]  x  [4][4];
  logic signed [6:0]  ax [4][4];
  logic signed [12:0] h  [4][4];
  logic signed [14:0] ah [4][4];
  logic signed [20:0] y  [4][2];
  logic signed [4:0]  w1a [16];
  logic signed [4:0]  w2a [8];
  logic signed [14:0] mul_a;
  logic signed [4:0]  mul_b;
  logic signed [19:0] prod;
  logic signed [20:0] acc, acc_nx;
  logic [1:0]         kk;

  assign kk = cnt[1:0];

  // Weight vectors viewed as arrays so the MAC step bits index them directly.
  for (genvar i = 0; i < 16; i++) begin : g_w1
    assign w1a[i] = w1r[i*5 +: 5];
  end
  for (genvar i = 0; i < 8; i++) begin : g_w2
    assign w2a[i] = w2r[i*5 +: 5];
  end

  // Shared MAC: operand mux, multiply, accumulate (cleared at k = 0).
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == MAC1) begin
      mul_a = 15'(ax[cnt[5:4]][kk]);
      mul_b = w1a[cnt[3:0]];
    end else if (state == MAC2) begin
      mul_a = ah[cnt[4:3]][kk];
      mul_b = w2a[cnt[2:0]];
    end
    prod   = 20'(mul_a) * 20'(mul_b);
    acc_nx = ((kk == 2'd0) ? 21'sd0 : acc) + 21'(prod);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (bus.in_valid && ncnt == 2'd3) state_nx = AGG1;
      AGG1: state_nx = MAC1;
      MAC1: if (cnt == 6'd63) state_nx = AGG2;
      AGG2: state_nx = MAC2;
      MAC2: if (cnt[4:0] == 5'd31) state_nx = OUT;
      OUT:  if (bus.out_ready && ncnt == 2'd3) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncnt <= '0;
      cnt  <= '0;
      acc  <= '0;
      w1r  <= '0;
      w2r  <= '0;
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 4; k++) begin
          x[n][k]  <= '0;
          ax[n][k] <= '0;
          h[n][k]  <= '0;
          ah[n][k] <= '0;
        end
        y[n][0] <= '0;
        y[n][1] <= '0;
      end
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          for (int k = 0; k < 4; k++) x[ncnt][k] <= bus.in_data[k*5 +: 5];
          ncnt <= ncnt + 2'd1;  // wraps to 0 after node 3
          if (ncnt == 2'd3) begin
            w1r <= w1;
            w2r <= w2;
          end
        end
        AGG1: begin
          for (int n = 0; n < 4; n++)
            for (int k = 0; k < 4; k++)
              ax[n][k] <= 7'(x[n][k]) + 7'(x[(n+3)%4][k]) + 7'(x[(n+1)%4][k]);
          cnt <= '0;
        end
        MAC1: begin
          acc <= acc_nx;
          if (kk == 2'd3) h[cnt[5:4]][cnt[3:2]] <= acc_nx[12:0];
          cnt <= cnt + 6'd1;  // wraps to 0 after the last step
        end
        AGG2: begin
          for (int n = 0; n < 4; n++)
            for (int k = 0; k < 4; k++)
              ah[n][k] <= 15'(h[n][k]) + 15'(h[(n+3)%4][k]) + 15'(h[(n+1)%4][k]);
          cnt <= '0;
        end
        MAC2: begin
          acc <= acc_nx;
          if (kk == 2'd3) y[cnt[4:3]][cnt[2]] <= acc_nx;
          cnt <= (cnt[4:0] == 5'd31) ? 6'd0 : cnt + 6'd1;
        end
        OUT: if (bus.out_ready) ncnt <= ncnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Result outputs are gated to zero outside OUT so a reset anywhere clears them.
  assign busy          = (state != LOAD);
  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == OUT);
  assign bus.out_node  = (state == OUT) ? ncnt : 2'd0;
  assign bus.out0      = (state == OUT) ? y[ncnt][0] : 21'sd0;
  assign bus.out1      = (state == OUT) ? y[ncnt][1] : 21'sd0;
endmodule

// File: tb/tb_gnn_serial_engine.sv
// Self-checking bench for gnn_serial_engine: directed and random vectors in a
// table, checked against a matrix-level reference model, plus reset sequences.
module tb_gnn_serial_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] w1;
  logic [39:0] w2;
  logic        busy;

  gnn_serial_engine_if bus ();

  gnn_serial_engine dut (
    .clk  (clk),
    .rst  (rst),
    .w1   (w1),
    .w2   (w2),
    .busy (busy),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [79:0]       x;
    logic [79:0]       w1;
    logic [39:0]       w2;
    logic [3:0][20:0]  e0;
    logic [3:0][20:0]  e1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Y = (A*((A*X)*W1))*W2 with A = I + ring adjacency, in plain integers.
  function automatic vec_t model(input vec_t v);
    int a [4][4];
    int xm [4][4];
    int ax [4][4];
    int hm [4][4];
    int ah [4][4];
    int wa [4][4];
    int wb [4][2];
    int ym [4][2];
    vec_t r;
    r = v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j]  = (i == j || (i+1)%4 == j || (j+1)%4 == i) ? 1 : 0;
        xm[i][j] = $signed(v.x[(i*4+j)*5 +: 5]);
        wa[j][i] = $signed(v.w1[(4*i+j)*5 +: 5]);
      end
    for (int k = 0; k < 4; k++)
      for (int o = 0; o < 2; o++) wb[k][o] = $signed(v.w2[(4*o+k)*5 +: 5]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ax[i][j] = 0;
        for (int m = 0; m < 4; m++) ax[i][j] += a[i][m] * xm[m][j];
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        hm[i][j] = 0;
        for (int m = 0; m < 4; m++) hm[i][j] += ax[i][m] * wa[m][j];
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ah[i][j] = 0;
        for (int m = 0; m < 4; m++) ah[i][j] += a[i][m] * hm[m][j];
      end
    for (int i = 0; i < 4; i++)
      for (int o = 0; o < 2; o++) begin
        ym[i][o] = 0;
        for (int m = 0; m < 4; m++) ym[i][o] += ah[i][m] * wb[m][o];
      end
    for (int i = 0; i < 4; i++) begin
      r.e0[i] = 21'(ym[i][0]);
      r.e1[i] = 21'(ym[i][1]);
    end
    return r;
  endfunction

  // Feeds the four beats (optionally with idle gaps); afterwards w1/w2 are
  // scrambled to show the pass uses the captured copies.
  task automatic load(input vec_t v, input bit gaps);
    w1 = v.w1;
    w2 = v.w2;
    for (int n = 0; n < 4; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      chk("in_ready_load", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = v.x[n*20 +: 20];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    w1 = 80'({$urandom, $urandom, $urandom});
    w2 = 40'({$urandom, $urandom});
  endtask

  task automatic run_pass(input vec_t v, input bit rnd, input bit stray);
    int lat;
    int got;
    int budget;
    bit stalled;
    longint pn, p0, p1;
    load(v, rnd);
    chk("in_ready_drop", bus.in_ready, 0);
    chk("busy_set", busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      if (bus.in_ready) chk("in_ready_window", bus.in_ready, 0);
      if (stray && lat == 20) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 20'($urandom);
      end else bus.in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, 98);
    got = 0; budget = 0; stalled = 0;
    pn = 0; p0 = 0; p1 = 0;
    while (got < 4 && budget < 200) begin
      if (stalled) begin
        chk("stall_node", bus.out_node, pn);
        chk("stall_out0", bus.out0, p0);
        chk("stall_out1", bus.out1, p1);
      end
      chk("out_valid", bus.out_valid, 1);
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_ready) begin
        chk("out_node", bus.out_node, got);
        chk("out0", bus.out0, $signed(v.e0[got]));
        chk("out1", bus.out1, $signed(v.e1[got]));
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        pn = bus.out_node; p0 = bus.out0; p1 = bus.out1;
      end
      @(negedge clk);
      budget++;
    end
    bus.out_ready = 1'b0;
    chk("out_count", got, 4);
    if (!rnd) chk("back_to_back", budget, 4);
    chk("in_ready_after", bus.in_ready, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", bus.out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_node"}, bus.out_node, 0);
    chk({tag, "_out0"}, bus.out0, 0);
    chk({tag, "_out1"}, bus.out1, 0);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    w1 = '0;
    w2 = '0;

    tbl[0] = '{x: {16{5'd15}}, w1: {16{5'd15}}, w2: {8{5'd15}},
               e0: {4{21'd486000}}, e1: {4{21'd486000}}};
    tbl[1] = '{x: {16{5'b10000}}, w1: {16{5'b10000}}, w2: {8{5'b10000}},
               e0: {4{-21'sd589824}}, e1: {4{-21'sd589824}}};
    tbl[2] = '{x: 80'd1, w1: {16{5'd1}}, w2: {8{5'd1}},
               e0: {21'd8, 21'd8, 21'd8, 21'd12}, e1: {21'd8, 21'd8, 21'd8, 21'd12}};
    for (int i = 3; i < 8; i++) begin
      tbl[i]    = '0;
      tbl[i].x  = 80'({$urandom, $urandom, $urandom});
      tbl[i].w1 = 80'({$urandom, $urandom, $urandom});
      tbl[i].w2 = 40'({$urandom, $urandom});
      tbl[i]    = model(tbl[i]);
    end

    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_pass(tbl[i], (i % 2) == 1, i == 0 || i == 5);

    // Reset with a partial node count in LOAD: next pass must start at node 0.
    for (int n = 0; n < 2; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 20'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(tbl[2], 1'b0, 1'b0);

    // Reset 30 cycles into MAC1.
    load(tbl[0], 1'b0);
    repeat (31) @(negedge clk);
    chk("mid_mac_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mac");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(tbl[0], 1'b0, 1'b0);

    // Reset in OUT after node 0 was taken.
    load(tbl[1], 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_out_latency", lat, 98);
    chk("rst_out_pre0", bus.out0, -589824);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rst_out_node1", bus.out_node, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_out");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(tbl[3], 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gnn_serial_engine.md
# gnn_serial_engine

Area-reduced, time-multiplexed implementation of the two-layer, 4-node ring-graph GNN computed by `top`. One shared signed multiply-accumulate unit is sequenced by an internal state machine across both layers. Node features stream in over a valid/ready handshake. Per-node results stream out over a second valid/ready handshake. Results are bit-exact with `top` for identical features and weights.

## Interface
- No parameters; the 4-node, 4-feature, 4-hidden, 2-output geometry and 5-bit operands are fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` holds one node's features.
- `in_ready` out 1: engine accepts a feature beat (high only in LOAD).
- `in_data` in 20: signed 5-bit features; x0 in [4:0], x1 in [9:5], x2 in [14:10], x3 in [19:15]; beats arrive in node order 0..3.
- `w1` in 80: layer-1 weights; weight from feature k to hidden j at [(4j+k)*5 +: 5] (w04 at [4:0], w37 at [79:75]).
- `w2` in 40: layer-2 weights; weight from hidden k to output o at [(4o+k)*5 +: 5] (w48 at [4:0], w79 at [39:35]).
- `out_valid` out 1: `out_node`/`out0`/`out1` are valid.
- `out_ready` in 1: consumer accepts the current result beat.
- `out_node` out 2: node index of the current result.
- `out0`, `out1` out 21 each: signed layer-2 outputs 0 and 1 for `out_node`.
- `busy` out 1: high in every state except LOAD.

## Operation
- **Math.** The graph is a ring; node n's neighbours are (n-1) mod 4 and (n+1) mod 4, and A = I + adjacency.
  - Layer 1: H = (A·X)·W1.
  - Layer 2: Y = (A·H)·W2.
  - No activation, no rounding, no saturation.
- **States:** LOAD → AGG1 → MAC1 → AGG2 → MAC2 → OUT → LOAD.
- **LOAD**
  - `in_ready` = 1; each accepted beat (`in_valid` & `in_ready`) writes node-counter slot, then the counter increments.
  - On the edge accepting beat 3: `w1` and `w2` are captured into internal registers and the state goes to AGG1. Later changes on `w1`/`w2` have no effect on this pass.
- **AGG1** (1 cycle): ax[n][k] = x[n][k] + x[n-1][k] + x[n+1][k]; 7-bit signed, range −48..45.
- **MAC1** (64 cycles):
  - Loop order: n outer, j middle, k inner. Each cycle performs one acc += ax[n][k]·w1[k][j].
  - acc is cleared at k = 0; h[n][j] is written at k = 3.
  - |h| ≤ 3072, so h fits 13-bit signed.
- **AGG2** (1 cycle): ah[n][j] is the ring sum of h, as in AGG1; 15-bit signed, |ah| ≤ 9216.
- **MAC2** (32 cycles):
  - Loop order: n, o, k. Each cycle performs one acc += ah[n][k]·w2[k][o].
  - y[n][o] is written at k = 3; |y| ≤ 589824, so it fits 21-bit signed without overflow.
- **Datapath sharing.** Exactly one 15×5 signed multiplier and one 21-bit accumulator are shared by MAC1 and MAC2. Operands are sign-extended before the multiply.
- **OUT**
  - Presents node 0..3 in order with `out_valid` = 1.
  - On each `out_valid` & `out_ready` the node index advances.
  - Acceptance of node 3 returns the state to LOAD with the node counter cleared.

## Timing
- **Reset values:**
  - state = LOAD, so `in_ready` = 1.
  - `busy` = 0, `out_valid` = 0, `out_node` = 0, `out0` = `out1` = 0.
  - All counters and accumulators = 0.
- **Latency:** `out_valid` rises exactly 98 cycles after the edge accepting feature beat 3 (1 + 64 + 1 + 32).
- **`in_ready`** drops on the cycle after beat 3 is accepted. `in_valid` while `in_ready` = 0 is ignored and the data is not captured.
- **`in_valid` gaps** during LOAD stall the engine indefinitely. The partial node count is retained.
- **`out_ready` low** holds `out_valid`, `out_node`, `out0` and `out1` stable; no beat is lost or repeated.
- **Back-to-back passes:** one result beat per cycle when `out_ready` is held high. `in_ready` = 1 on the cycle after the node-3 result is accepted.
- **`rst` asserted in any state** (including mid-MAC or mid-OUT) returns all outputs to reset values immediately. Partial results are discarded; the next pass starts from node 0.
- `busy` = 1 from the cycle after beat 3 is accepted through the last OUT cycle.

## Test plan
- **All 15s:** all features = 15, all weights = 15 → every node gives `out0` = `out1` = 486000.
- **All −16s:** all features = −16, all weights = −16 → every node gives `out0` = `out1` = −589824.
- **Ring aggregation:** x0 of node 0 = 1, all other features 0, all weights 1 → node 0: 12/12; nodes 1, 2, 3: 8/8.
- **Latency/handshake:** `out_valid` rises exactly 98 cycles after beat 3 is accepted. `in_ready` stays 0 over that window, and a stray `in_valid` pulse mid-MAC1 leaves the results unchanged.
- **Backpressure:** toggle `out_ready` randomly → nodes appear 0,1,2,3 exactly once each with stable data while stalled. Then `in_ready` = 1 and a second pass with new data yields correct results.
- **Reset mid-pass:** assert `rst` 30 cycles into MAC1 → outputs reset at once. After reload with all-15 data, the result is 486000.
